sky130_fd_io__hvclamp_seq_ctl: RTL and testbench
================================================

SKY130_FD_IO__HVCLAMP_SEQ_CTL -- requirements
Module: sky130_fd_io__hvclamp_seq_ctl

Interface
REQ-001 SHALL have parameter NCH, default 4: number of clamp channels, legal range 1..8.
REQ-002 SHALL have parameter DEB_CYC, default 4: consecutive high trig samples needed to engage a clamp, range 1..255.
REQ-003 SHALL have parameter HOLD_CYC, default 16: minimum clamp on-time after trig falls, range 1..65535.
REQ-004 SHALL have parameter MAX_CYC, default 1024: continuous CLAMP cycles after which a fault is flagged, range 2..65535.
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-007 SHALL have port en, input, 1: global arm enable.
REQ-008 SHALL have port trig, input, NCH: per-channel rail-event request, already synchronised to clk.
REQ-009 SHALL have port force_on, input, 1: test override that drives all clamps on.
REQ-010 SHALL have port clamp_on, output, NCH: per-channel clamp gate enable.
REQ-011 SHALL have port fault, output, NCH: sticky per-channel stuck-trigger flag.
REQ-012 SHALL have port busy, output, 1: high when any channel is not IDLE.

Function
REQ-013 Each channel SHALL run an independent FSM with states IDLE, DEBOUNCE, CLAMP, HOLD.
REQ-014 IDLE: en=1 and trig[i]=1 SHALL go to DEBOUNCE with debounce count=1; otherwise stay.
REQ-015 DEBOUNCE: trig[i]=0 or en=0 SHALL go to IDLE; count reaching DEB_CYC with trig[i]=1 SHALL go to CLAMP; DEB_CYC=1 SHALL go IDLE->CLAMP directly.
REQ-016 Latency: trig[i] high on cycles k..k+DEB_CYC-1 SHALL give clamp_on[i]=1 from cycle k+DEB_CYC.
REQ-017 CLAMP: trig[i]=0 SHALL go to HOLD and load hold timer with HOLD_CYC; trig[i]=1 SHALL stay; en SHALL NOT affect CLAMP or HOLD.
REQ-018 HOLD: trig[i]=1 SHALL return to CLAMP (hold timer discarded, CLAMP run counter restarted); else timer decrements once per cycle, saturating at 0.
REQ-019 Staggered release: a HOLD channel with timer=0 SHALL go to IDLE only if it is the lowest-indexed such channel this cycle; others wait in HOLD with timer 0; at most one clamp_on bit falls per cycle.
REQ-020 clamp_on[i] SHALL be registered and equal 1 exactly in CLAMP or HOLD, OR'd with registered force_on.
REQ-021 force_on SHALL NOT alter FSM state or counters; its deassertion releases only channels in IDLE/DEBOUNCE.
REQ-022 A CLAMP run counter SHALL count consecutive CLAMP cycles, saturating; reaching MAX_CYC SHALL set fault[i]=1, cleared only by rst; clamp stays on.
REQ-023 busy SHALL be registered OR of (state != IDLE) across channels.
REQ-024 Simultaneous trig on several channels SHALL engage each independently in the same cycle; no engage arbitration.

Reset
REQ-025 rst=1 SHALL on the next edge set all FSMs to IDLE, clear all counters, and drive clamp_on=0, fault=0, busy=0 (and evt_cnt=0 when compiled).
REQ-026 rst asserted mid-CLAMP/HOLD SHALL drop clamp_on on the next edge, no hold or stagger applied.

Configuration
REQ-027 Macro SKY130_FD_IO_HVCLAMP_EVTCNT_EN defined SHALL add output evt_cnt, width 8*NCH, channel i in bits [8i+7:8i], counting entries into CLAMP from IDLE/DEBOUNCE, saturating at 255, HOLD->CLAMP not counted.
REQ-028 Macro undefined SHALL omit the evt_cnt port and its counters; all other behaviour identical.

Verification
REQ-029 NCH=4, DEB_CYC=4: trig[0] high 3 cycles then low -> clamp_on stays 0, channel back to IDLE, busy falls.
REQ-030 trig[1] high from cycle 10 -> clamp_on[1]=1 at cycle 14; trig low at 20 -> clamp_on[1]=0 at cycle 20+HOLD_CYC+1=37.
REQ-031 trig[0..3] all high 4 cycles then low together -> clamp_on bits fall on four consecutive cycles, bit 0 first.
REQ-032 MAX_CYC=32, trig[2] held high -> fault[2]=1 exactly 32 cycles after clamp_on[2] rose; stays after trig drop until rst.
REQ-033 en=0 during DEBOUNCE -> no clamp; en=0 during CLAMP -> clamp holds; force_on=1 -> clamp_on=4'hF next cycle, FSM states unchanged.
REQ-034 EVTCNT_EN: 300 engage events on channel 3 -> evt_cnt[31:24]=255; rst mid-HOLD -> all outputs 0 next cycle.

Source files
------------

// File: rtl/sky130_fd_io__hvclamp_seq_ctl.sv
// Per-channel high-voltage clamp sequencer: debounced engage, timed hold, staggered release.
// Optional per-channel engage-event counters are enabled with SKY130_FD_IO_HVCLAMP_EVTCNT_EN.
module sky130_fd_io__hvclamp_seq_ctl #(
  parameter int NCH      = 4,
  parameter int DEB_CYC  = 4,
  parameter int HOLD_CYC = 16,
  parameter int MAX_CYC  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NCH-1:0]   trig,
  input  logic             force_on,
  output logic [NCH-1:0]   clamp_on,
  output logic [NCH-1:0]   fault,
`ifdef SKY130_FD_IO_HVCLAMP_EVTCNT_EN
  output logic [8*NCH-1:0] evt_cnt,
`endif
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DEB   = 2'd1;
  localparam logic [1:0] S_CLAMP = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [7:0]  DEB_LIM  = 8'(DEB_CYC);
  localparam logic [15:0] HOLD_LIM = 16'(HOLD_CYC);
  localparam logic [15:0] MAX_LIM  = 16'(MAX_CYC);

  // Packed per-channel FSM state, kept visible for debug probing.
  logic [NCH-1:0][1:0]  state, nxt_st;
  logic [NCH-1:0][7:0]  deb, nxt_deb;
  logic [NCH-1:0][15:0] hold, nxt_hold, hold_dec;
  logic [NCH-1:0][15:0] run, nxt_run;
  logic [NCH-1:0]       enter, nxt_on, nxt_fault, nxt_busy;
  logic                 granted;

  always_comb begin
    granted = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      nxt_st[i]   = state[i];
      nxt_deb[i]  = deb[i];
      nxt_hold[i] = hold[i];
      nxt_run[i]  = run[i];
      enter[i]    = 1'b0;
      hold_dec[i] = (hold[i] == 16'd0) ? 16'd0 : hold[i] - 16'd1;
      case (state[i])
        S_IDLE: begin
          if (en && trig[i]) begin
            if (DEB_CYC == 1) begin
              nxt_st[i] = S_CLAMP;
              nxt_run[i] = 16'd0;
              enter[i] = 1'b1;
            end else begin
              nxt_st[i] = S_DEB;
              nxt_deb[i] = 8'd1;
            end
          end
        end
        S_DEB: begin
          if (!en || !trig[i]) begin
            nxt_st[i] = S_IDLE;
            nxt_deb[i] = 8'd0;
          end else if (deb[i] + 8'd1 == DEB_LIM) begin
            nxt_st[i] = S_CLAMP;
            nxt_deb[i] = 8'd0;
            nxt_run[i] = 16'd0;
            enter[i] = 1'b1;
          end else begin
            nxt_deb[i] = deb[i] + 8'd1;
          end
        end
        S_CLAMP: begin
          if (!trig[i]) begin
            nxt_st[i] = S_HOLD;
            nxt_hold[i] = HOLD_LIM;
            nxt_run[i] = 16'd0;
          end else if (run[i] != MAX_LIM) begin
            nxt_run[i] = run[i] + 16'd1;
          end
        end
        default: begin
          if (trig[i]) begin
            nxt_st[i] = S_CLAMP;
            nxt_hold[i] = 16'd0;
            nxt_run[i] = 16'd0;
          end else begin
            nxt_hold[i] = hold_dec[i];
            // Only the lowest expired channel releases per cycle; the rest wait at zero.
            if (hold_dec[i] == 16'd0 && !granted) begin
              nxt_st[i] = S_IDLE;
              granted = 1'b1;
            end
          end
        end
      endcase
      nxt_on[i]    = (nxt_st[i] == S_CLAMP) || (nxt_st[i] == S_HOLD);
      nxt_fault[i] = fault[i] || ((nxt_st[i] == S_CLAMP) && (nxt_run[i] == MAX_LIM));
      nxt_busy[i]  = (nxt_st[i] != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= '0;
      deb      <= '0;
      hold     <= '0;
      run      <= '0;
      clamp_on <= '0;
      fault    <= '0;
      busy     <= 1'b0;
`ifdef SKY130_FD_IO_HVCLAMP_EVTCNT_EN
      evt_cnt  <= '0;
`endif
    end else begin
      state    <= nxt_st;
      deb      <= nxt_deb;
      hold     <= nxt_hold;
      run      <= nxt_run;
      clamp_on <= nxt_on | {NCH{force_on}};
      fault    <= nxt_fault;
      busy     <= |nxt_busy;
`ifdef SKY130_FD_IO_HVCLAMP_EVTCNT_EN
      for (int i = 0; i < NCH; i++) begin
        if (enter[i] && evt_cnt[8*i +: 8] != 8'hFF)
          evt_cnt[8*i +: 8] <= evt_cnt[8*i +: 8] + 8'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sky130_fd_io__hvclamp_seq_ctl.sv
// Directed bench for the clamp sequencer: debounce, hold timing, staggered release, fault, force, reset.
module tb_sky130_fd_io__hvclamp_seq_ctl;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] trig;
  logic       force_on;
  logic [3:0] clamp_on;
  logic [3:0] fault;
  logic       busy;
`ifdef SKY130_FD_IO_HVCLAMP_EVTCNT_EN
  logic [31:0] evt_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  sky130_fd_io__hvclamp_seq_ctl #(
    .NCH(4), .DEB_CYC(4), .HOLD_CYC(16), .MAX_CYC(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .trig(trig),
    .force_on(force_on),
    .clamp_on(clamp_on),
    .fault(fault),
`ifdef SKY130_FD_IO_HVCLAMP_EVTCNT_EN
    .evt_cnt(evt_cnt),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; trig = 4'h0; force_on = 1'b0;
    step(2);
    check("rst_clamp", 32'(clamp_on), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
`ifdef SKY130_FD_IO_HVCLAMP_EVTCNT_EN
    check("rst_evt", evt_cnt, 32'h0);
`endif
    rst = 1'b0; en = 1'b1;

    // Short pulse: three samples never reach the debounce limit.
    trig = 4'b0001;
    step(1);
    check("deb_busy", 32'(busy), 32'h1);
    step(2);
    check("deb_short_clamp", 32'(clamp_on), 32'h0);
    trig = 4'b0000;
    step(1);
    check("deb_abort_clamp", 32'(clamp_on), 32'h0);
    check("deb_abort_busy", 32'(busy), 32'h0);

    // Engage latency and hold timing on channel 1.
    trig = 4'b0010;
    step(3);
    check("eng_pre", 32'(clamp_on), 32'h0);
    step(1);
    check("eng_on", 32'(clamp_on), 32'h2);
    step(5);
    check("eng_stay", 32'(clamp_on), 32'h2);
    trig = 4'b0000;
    step(16);
    check("hold_last", 32'(clamp_on), 32'h2);
    check("hold_busy", 32'(busy), 32'h1);
    step(1);
    check("hold_release", 32'(clamp_on), 32'h0);
    check("hold_idle_busy", 32'(busy), 32'h0);

    // All channels together: engage in the same cycle, release staggered from bit 0.
    trig = 4'b1111;
    step(4);
    check("all_on", 32'(clamp_on), 32'hF);
    trig = 4'b0000;
    step(16);
    check("stag_0", 32'(clamp_on), 32'hF);
    step(1);
    check("stag_1", 32'(clamp_on), 32'hE);
    step(1);
    check("stag_2", 32'(clamp_on), 32'hC);
    step(1);
    check("stag_3", 32'(clamp_on), 32'h8);
    step(1);
    check("stag_4", 32'(clamp_on), 32'h0);
    check("stag_busy", 32'(busy), 32'h0);

    // Enable dropped during debounce aborts; dropped during clamp is ignored.
    trig = 4'b0001;
    step(2);
    en = 1'b0;
    step(1);
    check("en_deb_busy", 32'(busy), 32'h0);
    step(4);
    check("en_off_clamp", 32'(clamp_on), 32'h0);
    en = 1'b1;
    step(4);
    check("en_eng", 32'(clamp_on), 32'h1);
    en = 1'b0;
    step(5);
    check("en_clamp_hold", 32'(clamp_on), 32'h1);
    trig = 4'b0000;
    step(16);
    check("en_hold_on", 32'(clamp_on), 32'h1);
    step(1);
    check("en_hold_off", 32'(clamp_on), 32'h0);
    en = 1'b1;

    // Force override leaves the FSMs alone; release only frees idle channels.
    force_on = 1'b1;
    step(1);
    check("force_on", 32'(clamp_on), 32'hF);
    check("force_busy", 32'(busy), 32'h0);
    check("force_state", 32'(dut.state), 32'h0);
    trig = 4'b0100;
    step(4);
    check("force_eng", 32'(clamp_on), 32'hF);
    check("force_state_clamp", 32'(dut.state), 32'h20);
    force_on = 1'b0;
    trig = 4'b0000;
    step(1);
    check("force_release", 32'(clamp_on), 32'h4);
    step(16);
    check("force_after", 32'(clamp_on), 32'h0);

    // Stuck trigger on channel 2 raises a sticky fault after MAX_CYC clamp cycles.
    trig = 4'b0100;
    step(4);
    check("flt_eng", 32'(clamp_on), 32'h4);
    step(31);
    check("flt_pre", 32'(fault), 32'h0);
    step(1);
    check("flt_set", 32'(fault), 32'h4);
    check("flt_clamp", 32'(clamp_on), 32'h4);
    trig = 4'b0000;
    step(17);
    check("flt_sticky", 32'(fault), 32'h4);
    check("flt_released", 32'(clamp_on), 32'h0);

    // Reset in the middle of a hold drops everything on the next edge.
    trig = 4'b1000;
    step(4);
    trig = 4'b0000;
    step(3);
    check("pre_rst_hold", 32'(clamp_on), 32'h8);
    rst = 1'b1;
    step(1);
    check("rst_hold_clamp", 32'(clamp_on), 32'h0);
    check("rst_hold_fault", 32'(fault), 32'h0);
    check("rst_hold_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    step(1);
    check("rst_stays_off", 32'(clamp_on), 32'h0);

`ifdef SKY130_FD_IO_HVCLAMP_EVTCNT_EN
    // A re-trigger during hold returns to clamp without counting as a new engage.
    trig = 4'b1000;
    step(4);
    trig = 4'b0000;
    step(2);
    trig = 4'b1000;
    step(2);
    trig = 4'b0000;
    step(17);
    check("evt_one", evt_cnt, 32'h0100_0000);
    for (int k = 0; k < 299; k++) begin
      trig = 4'b1000;
      step(4);
      trig = 4'b0000;
      step(17);
    end
    check("evt_sat", evt_cnt, 32'hFF00_0000);
    trig = 4'b1000;
    step(4);
    trig = 4'b0000;
    step(2);
    rst = 1'b1;
    step(1);
    check("evt_rst", evt_cnt, 32'h0);
    check("evt_rst_clamp", 32'(clamp_on), 32'h0);
    rst = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
